// File: rtl/l2_arbiter_if.sv
// Bundle of the I-cache, D-cache and shared L2 port signals around the L2 arbiter.
// The slave modport is the arbiter's view; master is the requesters/L2 side.
interface l2_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              l2_resp;
    logic [LINE_W-1:0] l2_rdata;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic              i_resp;
    logic              d_resp;
    logic [LINE_W-1:0] i_rdata;
    logic [LINE_W-1:0] d_rdata;
    logic              grant_i;
    logic              grant_d;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_resp, l2_rdata,
        output l2_read, l2_write, l2_addr, l2_wdata, i_resp, d_resp,
               i_rdata, d_rdata, grant_i, grant_d
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_resp, l2_rdata,
        input  l2_read, l2_write, l2_addr, l2_wdata, i_resp, d_resp,
               i_rdata, d_rdata, grant_i, grant_d
    );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-cache and D-cache miss paths.
// Grant is held for a whole L2 transaction; request/data pass through combinationally.
//
// state | meaning
// IDLE  | no owner; arbitrate requests sampled this cycle
// GNT_I | I-cache owns L2 until l2_resp or i_read drops
// GNT_D | D-cache owns L2 until l2_resp or its request drops
module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    l2_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_d, last_d_nxt;   // 1: D-cache was served last
    logic   i_req, d_req;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_d_nxt   = last_d;
        bus.l2_read  = 1'b0;
        bus.l2_write = 1'b0;
        bus.l2_addr  = '0;
        bus.l2_wdata = '0;
        bus.i_resp   = 1'b0;
        bus.d_resp   = 1'b0;
        bus.i_rdata  = '0;
        bus.d_rdata  = '0;
        bus.grant_i  = 1'b0;
        bus.grant_d  = 1'b0;

        case (state)
            IDLE: begin
                // Ties go to whichever side was not served last.
                if (i_req && d_req)
                    state_nxt = last_d ? GNT_I : GNT_D;
                else if (i_req)
                    state_nxt = GNT_I;
                else if (d_req)
                    state_nxt = GNT_D;
            end

            GNT_I: begin
                bus.grant_i = 1'b1;
                bus.l2_read = bus.i_read;
                bus.l2_addr = bus.i_addr;
                bus.i_resp  = bus.l2_resp;
                bus.i_rdata = bus.l2_rdata;
                if (bus.l2_resp) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b0;
                end else if (!i_req) begin
                    state_nxt  = IDLE;
                end
            end

            GNT_D: begin
                bus.grant_d  = 1'b1;
                bus.l2_read  = bus.d_read;
                bus.l2_write = bus.d_write;
                bus.l2_addr  = bus.d_addr;
                bus.l2_wdata = bus.d_wdata;
                bus.d_resp   = bus.l2_resp;
                bus.d_rdata  = bus.l2_rdata;
                if (bus.l2_resp) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b1;
                end else if (!d_req) begin
                    state_nxt  = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: fixed vector table, hand-written corner sequences and a
// randomized run checked against an ownership/round-robin reference model.
module tb_l2_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    localparam logic [ADDR_W-1:0] I_ADDR  = 16'h3000;
    localparam logic [ADDR_W-1:0] D_ADDR  = 16'h8010;
    localparam logic [LINE_W-1:0] RDATA   = {16{8'hA5}};
    localparam logic [LINE_W-1:0] D_WDATA = {8{16'h1234}};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    l2_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_proto = 1'b1;

    // Reference model: who owns the port (0 none, 1 I, 2 D) and who was served last.
    int owner = 0;
    int last  = 1;

    always @(posedge clk) begin
        if (reset_n && chk_proto) begin
            assert (!(bus.d_read && bus.d_write))
                else $error("illegal: d_read and d_write together");
            assert (!(bus.grant_i && !bus.i_read))
                else $error("protocol: i_read dropped while granted");
            assert (!(bus.grant_d && !(bus.d_read || bus.d_write)))
                else $error("protocol: d request dropped while granted");
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        logic              e_gi, e_gd;
        logic [ADDR_W-1:0] e_addr;
        e_gi   = (owner == 1);
        e_gd   = (owner == 2);
        e_addr = e_gi ? bus.i_addr : (e_gd ? bus.d_addr : '0);
        chk({tag, ".grant_i"},  bus.grant_i,  e_gi);
        chk({tag, ".grant_d"},  bus.grant_d,  e_gd);
        chk({tag, ".l2_read"},  bus.l2_read,  (e_gi & bus.i_read) | (e_gd & bus.d_read));
        chk({tag, ".l2_write"}, bus.l2_write, e_gd & bus.d_write);
        chk({tag, ".l2_addr"},  bus.l2_addr,  e_addr);
        chk({tag, ".l2_wdata"}, bus.l2_wdata, e_gd ? bus.d_wdata : '0);
        chk({tag, ".i_resp"},   bus.i_resp,   e_gi & bus.l2_resp);
        chk({tag, ".d_resp"},   bus.d_resp,   e_gd & bus.l2_resp);
        chk({tag, ".i_rdata"},  bus.i_rdata,  e_gi ? bus.l2_rdata : '0);
        chk({tag, ".d_rdata"},  bus.d_rdata,  e_gd ? bus.l2_rdata : '0);
    endtask

    // Advance the model over one clock edge using the inputs held across it.
    task automatic model_step();
        bit ir, dr;
        ir = bus.i_read;
        dr = bus.d_read | bus.d_write;
        if (owner == 0) begin
            if (ir && dr)  owner = (last == 2) ? 1 : 2;
            else if (ir)   owner = 1;
            else if (dr)   owner = 2;
        end else if (bus.l2_resp) begin
            last  = owner;
            owner = 0;
        end else if ((owner == 1 && !ir) || (owner == 2 && !dr)) begin
            owner = 0;
        end
    endtask

    task automatic clear_inputs();
        bus.i_read   = 1'b0;
        bus.i_addr   = I_ADDR;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_addr   = D_ADDR;
        bus.d_wdata  = D_WDATA;
        bus.l2_resp  = 1'b0;
        bus.l2_rdata = RDATA;
    endtask

    task automatic do_reset(string tag);
        clear_inputs();
        reset_n = 1'b0;
        owner   = 0;
        last    = 1;
        #3;
        check_outputs(tag);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit ir, dr, dw, rsp;
        bit gi, gd, irsp, drsp, lrd, lwr;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int seen[$];
        int cur, prev, len, gap, cyc;
        int exp_order[6];
        bit i_pend, d_pend;

        //          ir    dr    dw    rsp   | gi    gd    irsp  drsp  lrd   lwr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // ---------------- vector table ----------------
        do_reset("tbl.reset");
        for (int k = 0; k < 15; k++) begin
            string t;
            t = $sformatf("tbl[%0d]", k);
            bus.i_read  = tbl[k].ir;
            bus.d_read  = tbl[k].dr;
            bus.d_write = tbl[k].dw;
            bus.l2_resp = tbl[k].rsp;
            @(negedge clk);
            chk({t, ".grant_i"},  bus.grant_i,  tbl[k].gi);
            chk({t, ".grant_d"},  bus.grant_d,  tbl[k].gd);
            chk({t, ".i_resp"},   bus.i_resp,   tbl[k].irsp);
            chk({t, ".d_resp"},   bus.d_resp,   tbl[k].drsp);
            chk({t, ".l2_read"},  bus.l2_read,  tbl[k].lrd);
            chk({t, ".l2_write"}, bus.l2_write, tbl[k].lwr);
            chk({t, ".l2_addr"},  bus.l2_addr,
                tbl[k].gi ? I_ADDR : (tbl[k].gd ? D_ADDR : 16'h0));
            chk({t, ".l2_wdata"}, bus.l2_wdata, tbl[k].gd ? D_WDATA : '0);
            chk({t, ".i_rdata"},  bus.i_rdata,  tbl[k].gi ? RDATA : '0);
            chk({t, ".d_rdata"},  bus.d_rdata,  tbl[k].gd ? RDATA : '0);
            @(posedge clk);
            #1;
        end

        // ---------------- saturation: strict D,I,D,I,D,I ----------------
        do_reset("sat.reset");
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        exp_order  = '{2, 1, 2, 1, 2, 1};
        prev = 0; len = 0; gap = 0; cyc = 0;
        while (seen.size() < 6 && cyc < 80) begin
            @(negedge clk);
            cur = bus.grant_d ? 2 : (bus.grant_i ? 1 : 0);
            if (cur != 0 && prev == 0) begin
                if (seen.size() > 0) chk("sat.idle_gap", gap, 1);
                seen.push_back(cur);
                len = 0;
            end
            if (cur == 0 && prev != 0) begin
                chk("sat.grant_len", len, 3);
                gap = 0;
            end
            if (cur != 0) len++;
            else gap++;
            prev = cur;
            @(posedge clk);
            #1;
            bus.l2_resp = (cur != 0 && len == 2);
            cyc++;
        end
        chk("sat.grant_count", seen.size(), 6);
        for (int k = 0; k < 6 && k < seen.size(); k++)
            chk($sformatf("sat.order[%0d]", k), seen[k], exp_order[k]);

        // ---------------- async reset in the middle of GNT_D ----------------
        do_reset("arst.reset");
        bus.d_write = 1'b1;
        @(posedge clk);
        #3;
        chk("arst.grant_d_before", bus.grant_d, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst.l2_write", bus.l2_write, 1'b0);
        chk("arst.grant_d",  bus.grant_d,  1'b0);
        chk("arst.l2_addr",  bus.l2_addr,  16'h0);
        chk("arst.l2_wdata", bus.l2_wdata, '0);
        bus.i_read = 1'b1;
        #5;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("arst.regrant_d", bus.grant_d, 1'b1);
        chk("arst.regrant_i", bus.grant_i, 1'b0);
        chk("arst.l2_write2", bus.l2_write, 1'b1);

        // ---------------- abort: I drops before l2_resp ----------------
        do_reset("abort.reset");
        chk_proto  = 1'b0;
        bus.i_read = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort.grant_i", bus.grant_i, 1'b1);
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;
        bus.d_read = 1'b1;
        @(negedge clk);
        chk("abort.l2_read_drop", bus.l2_read, 1'b0);
        chk("abort.i_resp0", bus.i_resp, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort.idle_gi", bus.grant_i, 1'b0);
        chk("abort.idle_gd", bus.grant_d, 1'b0);
        chk("abort.i_resp1", bus.i_resp,  1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort.grant_d", bus.grant_d, 1'b1);
        chk("abort.d_addr",  bus.l2_addr, D_ADDR);
        @(posedge clk);
        #1;
        bus.l2_resp = 1'b1;
        @(negedge clk);
        chk("abort.d_resp", bus.d_resp, 1'b1);
        @(posedge clk);
        #1;
        clear_inputs();
        @(posedge clk);
        #1;
        chk_proto = 1'b1;

        // ---------------- randomized run against the model ----------------
        do_reset("rnd.reset");
        i_pend = 1'b0;
        d_pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!i_pend && $urandom_range(0, 3) == 0) begin
                i_pend     = 1'b1;
                bus.i_addr = ADDR_W'($urandom);
            end
            if (!d_pend && $urandom_range(0, 3) == 0) begin
                d_pend      = 1'b1;
                bus.d_addr  = ADDR_W'($urandom);
                bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 1) == 0) begin
                    bus.d_read = 1'b1; bus.d_write = 1'b0;
                end else begin
                    bus.d_read = 1'b0; bus.d_write = 1'b1;
                end
            end
            bus.i_read = i_pend;
            if (!d_pend) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end
            bus.l2_rdata = {$urandom, $urandom, $urandom, $urandom};
            bus.l2_resp  = (owner != 0) ? ($urandom_range(0, 2) == 0)
                                        : ($urandom_range(0, 7) == 0);
            @(negedge clk);
            check_outputs("rnd");
            @(posedge clk);
            if (owner == 1 && bus.l2_resp) i_pend = 1'b0;
            if (owner == 2 && bus.l2_resp) d_pend = 1'b0;
            model_step();
            #1;
        end

        clear_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
Arbitrates the single shared L2 cache port between the L1 instruction-cache miss path and the L1 data-cache miss/writeback path of the pipelined LC-3b.
Each requester holds a request until it sees its response. The arbiter grants one requester at a time and holds the grant for the whole L2 transaction. It then routes the response and read line back to the granted requester only.
Ties are resolved round-robin, so a long stream of data misses cannot starve instruction fetch, and the reverse.

Parameters:
ADDR_W, 16, byte address width (lc3b_word)
LINE_W, 128, cache line width in bits (8 words)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
i_read  input  1  I-cache line read request, held until i_resp
i_addr  input  ADDR_W  I-cache line address
d_read  input  1  D-cache line read request, held until d_resp
d_write  input  1  D-cache line writeback request, held until d_resp
d_addr  input  ADDR_W  D-cache line address
d_wdata  input  LINE_W  D-cache writeback line
l2_resp  input  1  L2 transaction complete (one-cycle pulse)
l2_rdata  input  LINE_W  L2 read line, valid with l2_resp
l2_read  output  1  read request to L2
l2_write  output  1  write request to L2
l2_addr  output  ADDR_W  address to L2
l2_wdata  output  LINE_W  write line to L2
i_resp  output  1  response pulse to I-cache
d_resp  output  1  response pulse to D-cache
i_rdata  output  LINE_W  read line to I-cache
d_rdata  output  LINE_W  read line to D-cache
grant_i  output  1  status: I-cache currently owns L2
grant_d  output  1  status: D-cache currently owns L2

Behaviour:
- Clocking and reset: single clock domain. Async reset (reset_n low) forces state IDLE and last_served = I. All outputs go to 0 immediately: l2_read, l2_write, i_resp, d_resp, grant_i, grant_d, and all address/data buses.
- States: IDLE, GNT_I, GNT_D.
- IDLE transitions, evaluated on clk rising edge:
  - Only i_read asserted -> GNT_I.
  - Only d_read or d_write asserted -> GNT_D.
  - Both requesters asserted -> grant the side not equal to last_served. After reset this is D first.
  - No request -> stay IDLE.
- IDLE outputs: no L2 request is issued, so arbitration costs 1 cycle. First l2_read/l2_write appears the cycle after the request is sampled.
- GNT_I:
  - l2_read = i_read, l2_write = 0, l2_addr = i_addr, l2_wdata = 0.
  - grant_i = 1.
  - i_resp = l2_resp combinationally.
  - i_rdata = l2_rdata.
- GNT_D:
  - l2_read = d_read, l2_write = d_write, l2_addr = d_addr, l2_wdata = d_wdata.
  - grant_d = 1.
  - d_resp = l2_resp combinationally.
  - d_rdata = l2_rdata.
- Completion: on l2_resp in GNT_x, set last_served = x and return to IDLE. There is always at least one IDLE cycle between grants.
- Response gating: the non-granted requester's resp is 0 and its rdata is 0. l2_resp while in IDLE is ignored and routed to no one.
- Abort: if the granted requester drops its request before l2_resp, return to IDLE the next edge. last_served is unchanged and no resp is generated. This is a protocol violation; the bench flags it with an assertion.
- Illegal input: d_read and d_write both high is illegal (assertion). If it occurs, forward both unchanged.
- Request stability: address and data must remain stable while the grant is held. The arbiter does not register them; they pass through combinationally.
- Reset mid-transaction: the grant is lost and the L2 request drops asynchronously. The L2 cache shares reset_n, so no transaction is left half-complete.
- Fairness bound: with both requesters saturated, grants strictly alternate D, I, D, I.

Test Plan:
- Lone I miss: i_read=1, i_addr=16'h3000 from cycle 0, l2_resp pulsed at cycle 5 with l2_rdata=128'hA5.. -> l2_read=1 with l2_addr=16'h3000 during cycles 1–5; i_resp=1 and i_rdata=A5.. in cycle 5; d_resp stays 0.
- D writeback: d_write=1, d_addr=16'h8010, d_wdata=128'h1234.. -> l2_write=1 with matching address/data from cycle 1 until l2_resp; d_resp pulses on l2_resp.
- Simultaneous after reset: i_read and d_read both high -> D granted first; after d_resp, one IDLE cycle; then I granted with l2_addr=i_addr.
- Saturation: both requesters re-request immediately after each resp for 6 transactions -> grant order D,I,D,I,D,I; each grant lasts until its l2_resp.
- Async reset mid-GNT_D: reset_n low for a half cycle -> l2_write, grant_d and l2_addr drop to 0 before the next clk edge; after release with both requesting, D is granted.
- Abort: in GNT_I, i_read drops before l2_resp -> IDLE the next cycle, no i_resp; a pending d_read is then granted.
